// File: rtl/sprite_pixel_arbiter_if.sv
// Bus between the game logic / video timing (master) and the sprite pixel
// arbiter (slave): raster position, per-frame sprite placement in, resolved
// pixel selection and frame status out.
interface sprite_pixel_arbiter_if;
    logic        active_video;
    logic [10:0] screen_x;
    logic [10:0] screen_y;
    logic [43:0] spr_x;
    logic [43:0] spr_y;
    logic [3:0]  spr_en;
    logic        pix_valid;
    logic [1:0]  pix_id;
    logic [13:0] pix_addr;
    logic        frame_tick;
    logic [3:0]  collision_mask;

    modport master (
        output active_video, screen_x, screen_y, spr_x, spr_y, spr_en,
        input  pix_valid, pix_id, pix_addr, frame_tick, collision_mask
    );

    modport slave (
        input  active_video, screen_x, screen_y, spr_x, spr_y, spr_en,
        output pix_valid, pix_id, pix_addr, frame_tick, collision_mask
    );
endinterface

// File: rtl/sprite_pixel_arbiter.sv
// Per-pixel sprite scheduler: four sprite slots share one ROM address path.
// Positions are shadow-latched at raster (0,0); stage 1 computes per-slot
// offsets and hits, stage 2 resolves fixed priority (3 > 2 > 1 > 0) and forms
// the row-major ROM address. Latency from raster inputs to pix_* is 2 clocks.
// Optional macro SPRITE_COLLISION_EN adds the per-frame collision mask;
// without it collision_mask is tied to 0.
module sprite_pixel_arbiter #(
    parameter int HOR_START = 296,
    parameter int VER_START = 35,
    parameter int SPR0_W = 128, parameter int SPR0_H = 128,
    parameter int SPR1_W = 128, parameter int SPR1_H = 128,
    parameter int SPR2_W = 18,  parameter int SPR2_H = 32,
    parameter int SPR3_W = 32,  parameter int SPR3_H = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sprite_pixel_arbiter_if.slave bus
);

    // Sprite width of a slot, as a 13-bit offset-domain value.
    function automatic logic [12:0] spr_w(input logic [1:0] idx);
        case (idx)
            2'd0:    spr_w = 13'(SPR0_W);
            2'd1:    spr_w = 13'(SPR1_W);
            2'd2:    spr_w = 13'(SPR2_W);
            2'd3:    spr_w = 13'(SPR3_W);
            default: spr_w = 13'(SPR0_W);
        endcase
    endfunction

    // Sprite height of a slot, as a 13-bit offset-domain value.
    function automatic logic [12:0] spr_h(input logic [1:0] idx);
        case (idx)
            2'd0:    spr_h = 13'(SPR0_H);
            2'd1:    spr_h = 13'(SPR1_H);
            2'd2:    spr_h = 13'(SPR2_H);
            2'd3:    spr_h = 13'(SPR3_H);
            default: spr_h = 13'(SPR0_H);
        endcase
    endfunction

    logic [10:0] r_sx [4];
    logic [10:0] r_sy [4];
    logic [3:0]  r_sen;
    logic        r_frame_tick;
    logic        w_frame_start;

    logic [12:0] w_dx [4];
    logic [12:0] w_dy [4];
    logic [3:0]  w_hit;

    logic [3:0]  r_hit;
    logic [6:0]  r_dx [4];
    logic [6:0]  r_dy [4];

    logic [1:0]  w_win;
    logic [13:0] w_addr;

    logic        r_pix_valid;
    logic [1:0]  r_pix_id;
    logic [13:0] r_pix_addr;

    assign w_frame_start = (bus.screen_x == 11'd0) && (bus.screen_y == 11'd0);

    // Shadow-latch sprite placement once per frame so mid-frame updates cannot tear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_sx[i] <= 11'd0;
                r_sy[i] <= 11'd0;
            end
            r_sen        <= 4'b0000;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_start;
            if (w_frame_start) begin
                for (int i = 0; i < 4; i++) begin
                    r_sx[i] <= bus.spr_x[11*i +: 11];
                    r_sy[i] <= bus.spr_y[11*i +: 11];
                end
                r_sen <= bus.spr_en;
            end
        end
    end

    // Offset of the raster pixel from each sprite's top-left corner; the sign
    // bit rejects pixels left of / above the sprite, so clipped sprites never wrap.
    always_comb begin
        w_hit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_dx[i] = {2'b00, bus.screen_x} - 13'(HOR_START) - {2'b00, r_sx[i]}
                      + (spr_w(2'(i)) >> 1);
            w_dy[i] = {2'b00, bus.screen_y} - 13'(VER_START) - {2'b00, r_sy[i]}
                      + (spr_h(2'(i)) >> 1);
            w_hit[i] = bus.active_video & r_sen[i]
                     & ~w_dx[i][12] & (w_dx[i] < spr_w(2'(i)))
                     & ~w_dy[i][12] & (w_dy[i] < spr_h(2'(i)));
        end
    end

    // Stage 1 register: hit vector plus in-sprite offsets (all sprites fit in 7 bits).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_dx[i] <= 7'd0;
                r_dy[i] <= 7'd0;
            end
        end else begin
            r_hit <= w_hit;
            for (int i = 0; i < 4; i++) begin
                r_dx[i] <= w_dx[i][6:0];
                r_dy[i] <= w_dy[i][6:0];
            end
        end
    end

    // Fixed draw-order priority: bullets over planes, my plane over enemy.
    always_comb begin
        w_win = 2'd0;
        if (r_hit[3]) begin
            w_win = 2'd3;
        end else if (r_hit[2]) begin
            w_win = 2'd2;
        end else if (r_hit[1]) begin
            w_win = 2'd1;
        end else begin
            w_win = 2'd0;
        end
        w_addr = 14'(r_dy[w_win]) * 14'(spr_w(w_win)) + 14'(r_dx[w_win]);
    end

    // Stage 2 register: resolved pixel, zeroed when no sprite covers it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_valid <= 1'b0;
            r_pix_id    <= 2'd0;
            r_pix_addr  <= 14'd0;
        end else begin
            r_pix_valid <= |r_hit;
            r_pix_id    <= w_win;
            r_pix_addr  <= (|r_hit) ? w_addr : 14'd0;
        end
    end

    assign bus.pix_valid  = r_pix_valid;
    assign bus.pix_id     = r_pix_id;
    assign bus.pix_addr   = r_pix_addr;
    assign bus.frame_tick = r_frame_tick;

`ifdef SPRITE_COLLISION_EN
    // True when two or more bits of the hit vector are set.
    function automatic logic multi_hit(input logic [3:0] v);
        multi_hit = ((v & (v - 4'd1)) != 4'b0000);
    endfunction

    logic [3:0] r_coll_acc;
    logic [3:0] r_collision_mask;

    // Accumulate overlapping slots over a frame; publish and clear at the frame latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll_acc       <= 4'b0000;
            r_collision_mask <= 4'b0000;
        end else if (w_frame_start) begin
            r_collision_mask <= r_coll_acc;
            r_coll_acc       <= 4'b0000;
        end else if (multi_hit(w_hit)) begin
            r_coll_acc <= r_coll_acc | w_hit;
        end
    end

    assign bus.collision_mask = r_collision_mask;
`else
    assign bus.collision_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_sprite_pixel_arbiter.sv
// Self-checking bench for sprite_pixel_arbiter: directed raster points plus
// randomized pixels around randomly placed sprites, checked by a scoreboard
// fed from a geometric reference model (sprite rectangles in screen space).
module tb_sprite_pixel_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_pixel_arbiter_if bus();

    sprite_pixel_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int SW [4] = '{128, 128, 18, 32};
    localparam int SH [4] = '{128, 128, 32, 64};

    typedef struct {
        int          due;
        logic        v;
        logic [1:0]  id;
        logic [13:0] addr;
    } pix_e_t;

    typedef struct {
        int         due;
        logic       tick;
        logic [3:0] mask;
    } tick_e_t;

    pix_e_t  pq[$];
    tick_e_t tq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: what the game currently drives, and what the frame has latched.
    int         cur_x [4];
    int         cur_y [4];
    logic [3:0] cur_en;
    int         sh_x [4];
    int         sh_y [4];
    logic [3:0] sh_en;
    logic [3:0] m_acc;
    logic [3:0] m_mask;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Which latched sprite rectangles contain the pixel; highest slot wins.
    function automatic void ref_pixel(input int sx, input int sy, input logic av,
                                      output logic v, output logic [1:0] id,
                                      output logic [13:0] addr, output logic [3:0] hits);
        int ax, ay, l, t;
        v = 1'b0; id = 2'd0; addr = 14'd0; hits = 4'b0000;
        ax = sx - 296;
        ay = sy - 35;
        for (int s = 0; s < 4; s++) begin
            l = sh_x[s] - SW[s] / 2;
            t = sh_y[s] - SH[s] / 2;
            if (av && sh_en[s] && ax >= l && ax < l + SW[s] && ay >= t && ay < t + SH[s]) begin
                hits[s] = 1'b1;
                v       = 1'b1;
                id      = 2'(s);
                addr    = 14'((ay - t) * SW[s] + (ax - l));
            end
        end
    endfunction

    task automatic set_spr(input int s, input int x, input int y, input logic en);
        cur_x[s] = x;
        cur_y[s] = y;
        cur_en[s] = en;
        bus.spr_x[11*s +: 11] = 11'(x);
        bus.spr_y[11*s +: 11] = 11'(y);
        bus.spr_en[s] = en;
    endtask

    // Drive one raster position and record what the DUT must answer.
    task automatic px(input int sx, input int sy);
        logic       av;
        logic [3:0] h;
        logic       latch;
        pix_e_t     pe;
        tick_e_t    te;
        @(negedge clk);
        av = (sx >= 296 && sx < 1320 && sy >= 35 && sy < 803);
        bus.screen_x     = 11'(sx);
        bus.screen_y     = 11'(sy);
        bus.active_video = av;
        ref_pixel(sx, sy, av, pe.v, pe.id, pe.addr, h);
        pe.due = cyc + 2;
        pq.push_back(pe);
        if ($countones(h) >= 2) m_acc = m_acc | h;
        latch = (sx == 0 && sy == 0);
        if (latch) begin
            for (int s = 0; s < 4; s++) begin
                sh_x[s] = cur_x[s];
                sh_y[s] = cur_y[s];
            end
            sh_en = cur_en;
`ifdef SPRITE_COLLISION_EN
            m_mask = m_acc;
`else
            m_mask = 4'b0000;
`endif
            m_acc = 4'b0000;
        end
        te.due  = cyc + 1;
        te.tick = latch;
        te.mask = m_mask;
        tq.push_back(te);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_pix_valid", int'(bus.pix_valid), 0);
        chk("rst_pix_id", int'(bus.pix_id), 0);
        chk("rst_pix_addr", int'(bus.pix_addr), 0);
        chk("rst_frame_tick", int'(bus.frame_tick), 0);
        chk("rst_collision_mask", int'(bus.collision_mask), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero_outputs();
        pq.delete();
        tq.delete();
        for (int s = 0; s < 4; s++) begin
            sh_x[s] = 0;
            sh_y[s] = 0;
        end
        sh_en  = 4'b0000;
        m_acc  = 4'b0000;
        m_mask = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one step after each rising edge, compare every due expectation.
    always @(posedge clk) begin
        pix_e_t  e;
        tick_e_t t;
        #1;
        cyc++;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            if (e.due < cyc) begin
                chk("pix_stale_entry", e.due, cyc);
            end else begin
                chk("pix_valid", int'(bus.pix_valid), int'(e.v));
                chk("pix_id", int'(bus.pix_id), int'(e.id));
                chk("pix_addr", int'(bus.pix_addr), int'(e.addr));
            end
        end
        while (tq.size() > 0 && tq[0].due <= cyc) begin
            t = tq.pop_front();
            if (t.due < cyc) begin
                chk("tick_stale_entry", t.due, cyc);
            end else begin
                chk("frame_tick", int'(bus.frame_tick), int'(t.tick));
                chk("collision_mask", int'(bus.collision_mask), int'(t.mask));
            end
        end
    end

    initial begin
        bus.active_video = 1'b0;
        bus.screen_x     = 11'd5;
        bus.screen_y     = 11'd5;
        bus.spr_x        = 44'd0;
        bus.spr_y        = 44'd0;
        bus.spr_en       = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            cur_x[s] = 0; cur_y[s] = 0; sh_x[s] = 0; sh_y[s] = 0;
        end
        cur_en = 4'b0000; sh_en = 4'b0000; m_acc = 4'b0000; m_mask = 4'b0000;

        repeat (3) @(negedge clk);
        #1;
        chk_zero_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Slot 1 centred at (512,384): corners and just outside.
        set_spr(1, 512, 384, 1'b1);
        px(0, 0);
        px(744, 355);
        px(871, 482);
        px(872, 482);
        px(800, 400);

        // Reset mid-frame with slot 1 visible; invisible until the next latch.
        do_reset();
        px(744, 355);
        px(800, 400);
        px(0, 0);
        px(744, 355);
        px(800, 400);

        // Moving the sprite mid-frame only takes effect after the latch.
        px(700, 100);
        set_spr(1, 600, 384, 1'b1);
        px(744, 400);
        px(743, 400);
        px(832, 400);
        px(0, 0);
        px(744, 400);
        px(831, 400);
        px(832, 400);
        px(959, 400);
        px(960, 400);

        // Slots 0 and 3 sharing a centre: slot 3 wins where they overlap.
        set_spr(1, 600, 384, 1'b0);
        set_spr(0, 200, 200, 1'b1);
        set_spr(3, 200, 200, 1'b1);
        px(0, 0);
        repeat (40) px(296 + 184 + int'($urandom_range(31)), 35 + 168 + int'($urandom_range(63)));
        repeat (40) px(296 + 136 + int'($urandom_range(127)), 35 + 136 + int'($urandom_range(127)));
        px(0, 0);
        px(1000, 500);

        // Slot 2 clipped at the left edge.
        set_spr(0, 200, 200, 1'b0);
        set_spr(3, 200, 200, 1'b0);
        set_spr(2, 0, 100, 1'b1);
        px(0, 0);
        px(296, 119);
        px(295, 119);
        px(304, 119);
        px(305, 119);
        px(296, 150);
        px(296, 151);

        // All slots disabled: nothing visible, no collisions.
        for (int s = 0; s < 4; s++) set_spr(s, 512, 384, 1'b0);
        px(0, 0);
        repeat (200) px(int'($urandom_range(1343)), 1 + int'($urandom_range(804)));
        px(0, 0);
        px(10, 10);

        // Random frames: random placement, pixels biased around sprites.
        for (int f = 0; f < 20; f++) begin
            for (int s = 0; s < 4; s++)
                set_spr(s, int'($urandom_range(1023)), int'($urandom_range(767)),
                        1'($urandom_range(1)));
            if (f % 4 == 0) begin
                for (int s = 0; s < 4; s++) set_spr(s, 400, 300, 1'b1);
            end
            px(0, 0);
            for (int k = 0; k < 300; k++) begin
                int s, sx, sy;
                s = int'($urandom_range(3));
                if ($urandom_range(7) == 0) begin
                    sx = int'($urandom_range(1343));
                    sy = 1 + int'($urandom_range(804));
                end else begin
                    sx = 296 + cur_x[s] + int'($urandom_range(160)) - 80;
                    sy = 35 + cur_y[s] + int'($urandom_range(160)) - 80;
                    if (sx < 0) sx = 0;
                    if (sx > 1343) sx = 1343;
                    if (sy < 1) sy = 1;
                    if (sy > 805) sy = 805;
                end
                px(sx, sy);
            end
        end
        px(0, 0);
        px(20, 20);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", pq.size() + tq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_arbiter.md
Name: sprite_pixel_arbiter

Overview:
Per-pixel sprite scheduler for the 1024x768@60Hz plane-game renderer. It shares one ROM-address path among four sprite slots: enemy plane, my plane, enemy bullet and my bullet. For each pixel it resolves draw priority and computes the ROM address from coordinates, so no free-running address counters are needed. Sprite positions are shadow-latched once per frame to prevent tearing. It sits between the game logic and the colour mux/ROMs.

Parameters:
HOR_START, 296, first active screen_x (sync 136 + back porch 160)
VER_START, 35, first active screen_y (sync 6 + back porch 29)
SPR0_W / SPR0_H, 128 / 128, slot 0 size (enemy plane)
SPR1_W / SPR1_H, 128 / 128, slot 1 size (my plane)
SPR2_W / SPR2_H, 18 / 32, slot 2 size (enemy bullet, 576 px)
SPR3_W / SPR3_H, 32 / 64, slot 3 size (my bullet)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
active_video  in  1  high inside the visible area
screen_x  in  11  raw horizontal counter, 0..1343
screen_y  in  11  raw vertical counter, 0..805
spr_x  in  44  sprite centre x in active-area coordinates; slot i at [11i+10:11i]
spr_y  in  44  sprite centre y; same packing as spr_x
spr_en  in  4  slot enable, bit i = slot i
pix_valid  out  1  some enabled sprite covers the pixel
pix_id  out  2  winning slot
pix_addr  out  14  ROM address within the winning sprite
frame_tick  out  1  one-cycle pulse when the shadows load
collision_mask  out  4  slots that overlapped during the previous frame

Behaviour:
- Reset: state is asynchronous, active-high. Reset drives every output to 0 (pix_valid, pix_id, pix_addr, frame_tick, collision_mask) and clears all shadow x/y/en registers and the collision accumulator.
- Frame latch: on the clock edge where screen_x==0 && screen_y==0:
  - shadow x/y/en <= spr_x/spr_y/spr_en
  - frame_tick=1 for exactly that following cycle
  - Input changes at any other time have no effect until the next latch.
- Stage 1 (registered), per slot i:
  - dx_i = screen_x - HOR_START - x_i + W_i/2, computed in 13-bit signed
  - dy_i = screen_y - VER_START - y_i + H_i/2, computed in 13-bit signed
  - hit_i = active_video & en_i & 0<=dx_i<W_i & 0<=dy_i<H_i
  - Negative or oversize offsets never hit. Sprites partly off the left or top edge are therefore clipped, with no wrap-around.
- Stage 2 (registered):
  - Priority is fixed, slot 3 > 2 > 1 > 0, matching draw order: bullets over planes, my plane over enemy.
  - pix_valid = OR of hits.
  - pix_id = highest-priority hit.
  - pix_addr = dy*W + dx of the winner, row-major. Maximum value is 16383 for 128x128, so the result always fits in 14 bits.
  - When no slot hits: pix_id=0, pix_addr=0.
- Latency: exactly 2 clocks from screen_x/screen_y/active_video to pix_*. The pipeline runs every cycle with no stalls.
- Zero-width active region, e.g. during blanking: pix_valid=0.
- Reset mid-frame: outputs are 0 immediately. The sprites stay invisible (shadow en=0) until the next frame latch.
- screen_x/screen_y values outside the counter range: no hit is produced, because active_video is low.

Optional Feature:
Macro SPRITE_COLLISION_EN.
- Defined:
  - Each stage-1 cycle with two or more hit_i bits set ORs the hit vector into a 4-bit accumulator.
  - On the frame latch edge, collision_mask <= accumulator and the accumulator clears.
  - A hit in the same cycle as the latch is impossible, since that cycle is in blanking.
  - collision_mask holds its value for the whole following frame.
- Undefined: the accumulator logic is absent and collision_mask is tied to 0.

Test Plan:
- Assert rst mid-frame with slot 1 visible -> all outputs 0 on the next sample. After release, pix_valid stays 0 until a frame_tick.
- Slot 1 at (512,384), en=4'b0010, latched; drive screen_x=744, screen_y=355 -> 2 clocks later pix_valid=1, pix_id=1, pix_addr=0.
  - (871,482) -> pix_addr=16383.
  - (872,482) -> pix_valid=0.
- Slots 0 and 3 both centred at (200,200) -> pix_id=3 wherever they overlap. With SPRITE_COLLISION_EN, collision_mask=4'b1001 after the next frame_tick.
- Change spr_x[21:11] from 512 to 600 at screen_y=100 -> the hit window is unchanged for the rest of the frame. It moves by 88 px after frame_tick.
- Slot 2 at x=0, y=100: screen_x=296, screen_y=35+84=119 -> dx=9, dy=0, pix_addr=9. screen_x=295 -> pix_valid=0, since the pixel is not active.
- spr_en=0 with positions overlapping the whole screen -> pix_valid=0 for a full frame and collision_mask=0.
